// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes and state encoding for the convolver line feeder
package conv_pkg;
  localparam int BIT_LEN    = 8;
  localparam int M_LEN      = 3;
  localparam int ADDR_LEN   = 10;
  localparam int H_LEN      = 10;
  localparam int IMG_WIDTH  = 640;
  localparam int IMG_HEIGHT = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    FILL   = 2'd2,
    RUN    = 2'd3
  } state_t;
endpackage

// File: rtl/conv_line_feeder_if.sv
// rtl/conv_line_feeder_if.sv - control, pixel input and column output bundle of the line feeder
interface conv_line_feeder_if #(
  parameter int BIT_LEN  = conv_pkg::BIT_LEN,
  parameter int ADDR_LEN = conv_pkg::ADDR_LEN,
  parameter int H_LEN    = conv_pkg::H_LEN
);
  logic                i_start;
  logic                i_kernel;
  logic [ADDR_LEN-1:0] i_width;
  logic [H_LEN-1:0]    i_height;
  logic [BIT_LEN-1:0]  i_data;
  logic                i_valid;
  logic                o_ready;
  logic [BIT_LEN-1:0]  o_dato0;
  logic [BIT_LEN-1:0]  o_dato1;
  logic [BIT_LEN-1:0]  o_dato2;
  logic                o_selecK_I;
  logic                o_valid;
  logic                o_frame_done;

  modport master (
    output i_start, i_kernel, i_width, i_height, i_data, i_valid,
    input  o_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid, o_frame_done
  );

  modport slave (
    input  i_start, i_kernel, i_width, i_height, i_data, i_valid,
    output o_ready, o_dato0, o_dato1, o_dato2, o_selecK_I, o_valid, o_frame_done
  );
endinterface

// File: rtl/line_ram.sv
// rtl/line_ram.sv - one image row of storage: combinational read, clocked write, shared address
module line_ram #(
  parameter int BIT_LEN  = conv_pkg::BIT_LEN,
  parameter int ADDR_LEN = conv_pkg::ADDR_LEN,
  parameter int DEPTH    = conv_pkg::IMG_WIDTH
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [BIT_LEN-1:0]  wdata,
  output logic [BIT_LEN-1:0]  rdata
);
  logic [BIT_LEN-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/conv_line_feeder.sv
// rtl/conv_line_feeder.sv - row-major pixels to 3-pixel columns, plus kernel coefficient forwarding
// Optional build macro CONV_FEEDER_ZPAD_EN: emit zero-padded columns for the first two rows.
module conv_line_feeder #(
  parameter int BIT_LEN    = conv_pkg::BIT_LEN,
  parameter int M_LEN      = conv_pkg::M_LEN,
  parameter int ADDR_LEN   = conv_pkg::ADDR_LEN,
  parameter int IMG_WIDTH  = conv_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = conv_pkg::IMG_HEIGHT
) (
  input logic               CLK100MHZ,
  input logic               i_reset,
  conv_line_feeder_if.slave bus
);
  import conv_pkg::*;

  localparam logic [ADDR_LEN-1:0] W_MIN = ADDR_LEN'(M_LEN);
  localparam logic [ADDR_LEN-1:0] W_MAX = ADDR_LEN'(IMG_WIDTH);
  localparam logic [H_LEN-1:0]    H_MIN = H_LEN'(M_LEN);
  localparam logic [H_LEN-1:0]    H_MAX = H_LEN'(IMG_HEIGHT);
  localparam logic [H_LEN-1:0]    LAST_FILL_ROW = H_LEN'(M_LEN - 2);

  state_t              state;
  logic [ADDR_LEN-1:0] width_r, col;
  logic [H_LEN-1:0]    height_r, row;
  logic [3:0]          kcnt;
  logic [1:0]          kpos;
  logic [BIT_LEN-1:0]  kb0, kb1;
  logic [BIT_LEN-1:0]  lb0_rd, lb1_rd;
  logic                accept, img_we, last_col, last_row, dims_ok;

  assign accept   = bus.i_valid & bus.o_ready;
  assign img_we   = accept & ((state == FILL) | (state == RUN));
  assign last_col = (col == width_r - ADDR_LEN'(1));
  assign last_row = (row == height_r - H_LEN'(1));
  assign dims_ok  = (bus.i_width >= W_MIN) && (bus.i_width <= W_MAX) &&
                    (bus.i_height >= H_MIN) && (bus.i_height <= H_MAX);

  // Both rows share the column address; lb0 takes lb1's old value so rows shift upward.
  line_ram #(.BIT_LEN(BIT_LEN), .ADDR_LEN(ADDR_LEN), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk(CLK100MHZ), .we(img_we), .addr(col), .wdata(lb1_rd), .rdata(lb0_rd)
  );
  line_ram #(.BIT_LEN(BIT_LEN), .ADDR_LEN(ADDR_LEN), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk(CLK100MHZ), .we(img_we), .addr(col), .wdata(bus.i_data), .rdata(lb1_rd)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      state            <= IDLE;
      width_r          <= '0;
      height_r         <= '0;
      col              <= '0;
      row              <= '0;
      kcnt             <= '0;
      kpos             <= '0;
      kb0              <= '0;
      kb1              <= '0;
      bus.o_ready      <= 1'b0;
      bus.o_valid      <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_dato0      <= '0;
      bus.o_dato1      <= '0;
      bus.o_dato2      <= '0;
      bus.o_selecK_I   <= 1'b1;
    end else begin
      bus.o_valid      <= 1'b0;
      bus.o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            if (bus.i_kernel) begin
              state       <= LOAD_K;
              bus.o_ready <= 1'b1;
              kcnt        <= '0;
              kpos        <= '0;
            end else if (dims_ok) begin
              state       <= FILL;
              bus.o_ready <= 1'b1;
              width_r     <= bus.i_width;
              height_r    <= bus.i_height;
              col         <= '0;
              row         <= '0;
            end
          end
        end
        LOAD_K: begin
          if (accept) begin
            if (kpos == 2'd2) begin
              bus.o_dato2    <= bus.i_data;
              bus.o_dato1    <= kb1;
              bus.o_dato0    <= kb0;
              bus.o_selecK_I <= 1'b0;
              bus.o_valid    <= 1'b1;
              kpos           <= '0;
            end else begin
              if (kpos == 2'd0) kb0 <= bus.i_data;
              else              kb1 <= bus.i_data;
              kpos <= kpos + 2'd1;
            end
            kcnt <= kcnt + 4'd1;
            if (kcnt == 4'd8) begin
              bus.o_frame_done <= 1'b1;
              bus.o_ready      <= 1'b0;
              state            <= IDLE;
            end
          end
        end
        FILL, RUN: begin
          if (accept) begin
            bus.o_dato2    <= bus.i_data;
            bus.o_selecK_I <= 1'b1;
`ifdef CONV_FEEDER_ZPAD_EN
            // Buffers may hold another frame's rows until FILL completes, so mask them.
            bus.o_dato1 <= (row == '0) ? '0 : lb1_rd;
            bus.o_dato0 <= (state == FILL) ? '0 : lb0_rd;
            bus.o_valid <= 1'b1;
`else
            bus.o_dato1 <= lb1_rd;
            bus.o_dato0 <= lb0_rd;
            bus.o_valid <= (state == RUN);
`endif
            if (last_col) begin
              col <= '0;
              row <= row + H_LEN'(1);
              if (last_row) begin
                bus.o_frame_done <= 1'b1;
                bus.o_ready      <= 1'b0;
                state            <= IDLE;
              end else if (row == LAST_FILL_ROW) begin
                state <= RUN;
              end
            end else begin
              col <= col + ADDR_LEN'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_line_feeder.sv
// tb/tb_conv_line_feeder.sv - self-checking bench for conv_line_feeder (vectors, directed frames, random frames)
module tb_conv_line_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  conv_line_feeder_if bus ();

  conv_line_feeder dut (
    .CLK100MHZ(clk),
    .i_reset  (rst),
    .bus      (bus)
  );

  typedef struct {
    bit kern;
    int w;
    int h;
    bit exp_ready;
  } start_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // gap: 0 = i_valid always high, 1 = toggling 1/0, 2 = random
  // abort_after > 0: reset after that many accepted beats; mid_start >= 0: pulse i_start at that beat
  task automatic run_frame(input bit kern, input int w, input int h, input int gap,
                           input bit rnd, input int abort_after, input int mid_start);
    logic [7:0] pix[$];
    int n, idx, cyc, r, c;
    bit v;
    logic [7:0] e0, e1, e2;
    bit ev;
    n = kern ? 9 : w * h;
    for (int i = 0; i < n; i++) pix.push_back(rnd ? 8'($urandom) : (kern ? 8'(i + 1) : 8'(i)));

    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_kernel = kern;
    bus.i_width  = 10'(w);
    bus.i_height = 10'(h);
    bus.i_valid  = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("ready_after_start", 32'(bus.o_ready), 32'd1);

    idx = 0;
    cyc = 0;
    while (idx < n) begin
      if (cyc > 4 * n + 20) begin
        check("frame_timeout", 32'(idx), 32'(n));
        break;
      end
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.i_valid = v;
      bus.i_data  = v ? pix[idx] : 8'($urandom);
      bus.i_start = (v && idx == mid_start);
      bus.i_kernel = 1'b1;
      bus.i_width  = 10'd5;
      @(posedge clk);
      #1;
      if (v) begin
        if (kern) begin
          ev = (idx % 3 == 2);
          e2 = pix[idx];
          e1 = (idx >= 1) ? pix[idx-1] : 8'd0;
          e0 = (idx >= 2) ? pix[idx-2] : 8'd0;
        end else begin
          r  = idx / w;
          c  = idx % w;
          e2 = pix[idx];
          e1 = (r >= 1) ? pix[(r-1)*w + c] : 8'd0;
          e0 = (r >= 2) ? pix[(r-2)*w + c] : 8'd0;
`ifdef CONV_FEEDER_ZPAD_EN
          ev = 1'b1;
`else
          ev = (r >= 2);
`endif
        end
        check("o_valid", 32'(bus.o_valid), 32'(ev));
        if (ev) begin
          check("col_data", {8'd0, bus.o_dato2, bus.o_dato1, bus.o_dato0}, {8'd0, e2, e1, e0});
          check("o_selecK_I", 32'(bus.o_selecK_I), 32'(!kern));
        end
        check("o_frame_done", 32'(bus.o_frame_done), 32'(idx == n - 1));
        idx++;
      end else begin
        check("o_valid_gap", 32'(bus.o_valid), 32'd0);
        check("o_frame_done_gap", 32'(bus.o_frame_done), 32'd0);
      end
      cyc++;
      @(negedge clk);
      bus.i_start = 1'b0;
      if (abort_after > 0 && idx == abort_after) begin
        rst = 1'b1;
        bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 32'(bus.o_ready), 32'd0);
        check("abort_valid", 32'(bus.o_valid), 32'd0);
        check("abort_done", 32'(bus.o_frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_valid = 1'b0;
        return;
      end
    end
    bus.i_valid = 1'b1;
    bus.i_data  = 8'hA5;
    @(posedge clk);
    #1;
    check("idle_ready", 32'(bus.o_ready), 32'd0);
    check("idle_drop_valid", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  start_vec_t svec[10];

  initial begin
    bus.i_start  = 1'b0;
    bus.i_kernel = 1'b0;
    bus.i_width  = '0;
    bus.i_height = '0;
    bus.i_data   = '0;
    bus.i_valid  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_done", 32'(bus.o_frame_done), 32'd0);
    check("rst_dato", {8'd0, bus.o_dato2, bus.o_dato1, bus.o_dato0}, 32'd0);
    check("rst_selecK_I", 32'(bus.o_selecK_I), 32'd1);
    rst = 1'b0;

    svec[0] = '{0, 2, 3, 0};
    svec[1] = '{0, 3, 2, 0};
    svec[2] = '{0, 641, 3, 0};
    svec[3] = '{0, 3, 481, 0};
    svec[4] = '{0, 1023, 1023, 0};
    svec[5] = '{0, 3, 3, 1};
    svec[6] = '{1, 0, 0, 1};
    svec[7] = '{0, 640, 480, 1};
    svec[8] = '{0, 4, 3, 1};
    svec[9] = '{0, 0, 5, 0};
    foreach (svec[i]) begin
      @(negedge clk);
      bus.i_start  = 1'b1;
      bus.i_kernel = svec[i].kern;
      bus.i_width  = 10'(svec[i].w);
      bus.i_height = 10'(svec[i].h);
      bus.i_valid  = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      check($sformatf("start_vec%0d_ready", i), 32'(bus.o_ready), 32'(svec[i].exp_ready));
      check($sformatf("start_vec%0d_valid", i), 32'(bus.o_valid), 32'd0);
      if (svec[i].exp_ready) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("start_vec%0d_reset", i), 32'(bus.o_ready), 32'd0);
      end
      bus.i_valid = 1'b0;
    end

    run_frame(1, 0, 0, 0, 0, 0, -1);
    run_frame(0, 4, 3, 0, 0, 0, -1);
    run_frame(0, 4, 3, 1, 0, 0, -1);
    run_frame(0, 4, 3, 0, 0, 5, -1);
    run_frame(0, 4, 3, 0, 0, 0, -1);
    run_frame(0, 4, 3, 0, 0, 0, 9);
    run_frame(0, 4, 3, 1, 0, 0, 2);
    run_frame(0, 640, 3, 0, 1, 0, -1);
    run_frame(0, 3, 480, 0, 1, 0, -1);

    for (int k = 0; k < 14; k++) begin
      if (k % 4 == 3) run_frame(1, 0, 0, 2, 1, 0, -1);
      else run_frame(0, $urandom_range(3, 12), $urandom_range(3, 6), 2, 1,
                     (k % 5 == 4) ? $urandom_range(1, 8) : 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
